time_mod_sched: RTL and testbench

- Sample-rate controller that sequences a shared single-port sample BRAM for the time-modulation (echo/delay) effect.
- On each accepted `ready` strobe it runs four steps, then returns to idle:
  - writes the incoming sample into a circular buffer;
  - reads back the sample `delay` positions older;
  - mixes the two samples;
  - presents the result with a one-cycle valid pulse.
- Sits between the audio codec sample path and the audio output stage.
- Owns every BRAM access. No other block drives the buffer memory.

---
 rtl/time_mod_sched.sv | 155 +++++++++++++++
 tb/tb_time_mod_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_mod_sched.sv
// Sample-rate sequencer for the echo/delay effect. It owns the single-port sample BRAM.
// Each accepted sample is written, the delayed sample is read back, and the two are mixed.
module time_mod_sched #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned SHIFT  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready,
  input  logic [17:0]       audio_in,
  input  logic [7:0]        controls,
  input  logic [17:0]       mem_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [17:0]       mem_din,
  output logic [17:0]       audio_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned DATA_W = 18;
  localparam int unsigned SUM_W  = DATA_W + 1;
  localparam logic [ADDR_W-1:0] FILL_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] samp, samp_nxt;
  logic              bypass, bypass_nxt;
  logic [ADDR_W-1:0] delay, delay_nxt;
  logic              hist_ok, hist_ok_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] fill, fill_nxt;

  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              mem_we_nxt;
  logic [DATA_W-1:0] mem_din_nxt;
  logic [DATA_W-1:0] audio_out_nxt;
  logic              out_valid_nxt;
  logic              busy_nxt;
  logic              overrun_nxt;

  logic [ADDR_W-1:0] delay_code;
  logic [DATA_W-1:0] hist_d;
  logic [SUM_W-1:0]  mix_sum;
  logic [DATA_W-1:0] mix;

  // Delay in samples; the parameter constraint keeps it inside the buffer.
  assign delay_code = ADDR_W'(32'(controls[6:0]) << SHIFT);

  // Floor average of current and delayed sample; the 19-bit sum cannot overflow.
  assign hist_d  = hist_ok ? mem_dout : '0;
  assign mix_sum = {samp[DATA_W-1], samp} + {hist_d[DATA_W-1], hist_d};
  assign mix     = (bypass || (delay == '0)) ? samp : mix_sum[SUM_W-1:1];

  always_comb begin
    state_nxt     = state;
    samp_nxt      = samp;
    bypass_nxt    = bypass;
    delay_nxt     = delay;
    hist_ok_nxt   = hist_ok;
    wr_ptr_nxt    = wr_ptr;
    fill_nxt      = fill;
    mem_addr_nxt  = '0;
    mem_we_nxt    = 1'b0;
    mem_din_nxt   = mem_din;
    audio_out_nxt = audio_out;
    out_valid_nxt = 1'b0;
    busy_nxt      = busy;
    overrun_nxt   = overrun;

    case (state)
      S_IDLE: begin
        if (ready) begin
          samp_nxt     = audio_in;
          bypass_nxt   = controls[7];
          delay_nxt    = delay_code;
          mem_we_nxt   = 1'b1;
          mem_addr_nxt = wr_ptr;
          mem_din_nxt  = audio_in;
          busy_nxt     = 1'b1;
          state_nxt    = S_WRITE;
        end
      end
      S_WRITE: begin
        // wr_ptr still holds the address being written this cycle.
        hist_ok_nxt  = (fill >= delay);
        mem_addr_nxt = wr_ptr - delay;
        wr_ptr_nxt   = wr_ptr + ADDR_W'(1);
        fill_nxt     = (fill == FILL_MAX) ? fill : fill + ADDR_W'(1);
        state_nxt    = S_READ;
      end
      S_READ: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        audio_out_nxt = mix;
        out_valid_nxt = 1'b1;
        busy_nxt      = 1'b0;
        state_nxt     = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    // A strobe that lands while the sequence is running is lost.
    if (ready && (state != S_IDLE)) begin
      overrun_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      samp      <= '0;
      bypass    <= 1'b0;
      delay     <= '0;
      hist_ok   <= 1'b0;
      wr_ptr    <= '0;
      fill      <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_din   <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      samp      <= samp_nxt;
      bypass    <= bypass_nxt;
      delay     <= delay_nxt;
      hist_ok   <= hist_ok_nxt;
      wr_ptr    <= wr_ptr_nxt;
      fill      <= fill_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_we    <= mem_we_nxt;
      mem_din   <= mem_din_nxt;
      audio_out <= audio_out_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_time_mod_sched.sv
// Bench for time_mod_sched: a BRAM model plus a sample-history reference model.
// Directed scenarios are followed by randomized traffic.
module tb_time_mod_sched;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned SHIFT  = 4;
  localparam int DEPTH = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              ready;
  logic [17:0]       audio_in;
  logic [7:0]        controls;
  logic [17:0]       mem_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [17:0]       mem_din;
  logic [17:0]       audio_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  time_mod_sched #(.ADDR_W(ADDR_W), .SHIFT(SHIFT)) dut (
    .clock(clock), .reset(reset), .ready(ready), .audio_in(audio_in),
    .controls(controls), .mem_dout(mem_dout), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_din(mem_din), .audio_out(audio_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Single-port BRAM; never-written locations return junk so missing history gating shows.
  logic [17:0]      ram [DEPTH];
  logic [DEPTH-1:0] written = '0;
  always @(posedge clock) begin
    if (mem_we) begin
      ram[mem_addr]     <= mem_din;
      written[mem_addr] <= 1'b1;
    end
    mem_dout <= written[mem_addr] ? ram[mem_addr] : (18'h2AB5C ^ {10'd0, mem_addr});
  end

  // Reference: all samples accepted since the last reset, as signed integers.
  int hist[$];

  function automatic int sx(input logic [17:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_step(input logic [17:0] s, input logic [7:0] c,
                            output logic [17:0] eo, output int wa, output int ra);
    int k, dly, fillv, d;
    k     = hist.size();
    dly   = int'(c[6:0]) * (1 << SHIFT);
    wa    = k % DEPTH;
    ra    = ((k - dly) % DEPTH + DEPTH) % DEPTH;
    fillv = (k < DEPTH - 1) ? k : DEPTH - 1;
    d     = 0;
    if (dly > 0 && fillv >= dly) d = hist[k - dly];
    if (c[7] || dly == 0) eo = s;
    else eo = 18'((sx(s) + d) >>> 1);
    hist.push_back(sx(s));
  endtask

  logic              cap_we1, cap_we2, cap_busy1, cap_busy4, cap_valid3, cap_valid4;
  logic [ADDR_W-1:0] cap_addr1, cap_addr2;
  logic [17:0]       cap_din1, cap_out4;

  // One strobe, then capture the bus in T+1..T+4; inputs are scrambled after acceptance.
  task automatic run_sample(input logic [17:0] s, input logic [7:0] c);
    @(negedge clock);
    ready = 1'b1; audio_in = s; controls = c;
    @(posedge clock); #1;
    ready = 1'b0; audio_in = 18'($urandom); controls = 8'($urandom);
    cap_we1 = mem_we; cap_addr1 = mem_addr; cap_din1 = mem_din; cap_busy1 = busy;
    @(posedge clock); #1;
    cap_we2 = mem_we; cap_addr2 = mem_addr;
    @(posedge clock); #1;
    cap_valid3 = out_valid;
    @(posedge clock); #1;
    cap_valid4 = out_valid; cap_out4 = audio_out; cap_busy4 = busy;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0; ready = 1'b0;
    hist.delete();
  endtask

  task automatic test_reset();
    int vcount;
    @(negedge clock);
    reset = 1'b1; ready = 1'b1; audio_in = 18'h12345; controls = 8'h00;
    @(posedge clock); #1;
    checks++;
    if ({mem_addr, mem_we, mem_din, audio_out, out_valid, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0h we=%0b din=%0h out=%0h v=%0b busy=%0b ovr=%0b, want all 0",
               mem_addr, mem_we, mem_din, audio_out, out_valid, busy, overrun);
    end
    @(negedge clock);
    reset = 1'b0; ready = 1'b0;
    hist.delete();
    vcount = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (out_valid || busy || mem_we) vcount++;
    end
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL reset_ready_ignored: got %0d active cycles, want 0", vcount);
    end
  endtask

  task automatic test_basic();
    logic [17:0] eo; int wa, ra;
    do_reset();
    model_step(18'h00100, 8'h00, eo, wa, ra);
    run_sample(18'h00100, 8'h00);
    checks++;
    if (cap_we1 !== 1'b1 || cap_addr1 !== ADDR_W'(0) || cap_din1 !== 18'h00100 || cap_busy1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_write: got we=%0b addr=%0h din=%0h busy=%0b, want 1 0 100 1",
               cap_we1, cap_addr1, cap_din1, cap_busy1);
    end
    checks++;
    if (cap_we2 !== 1'b0 || cap_addr2 !== ADDR_W'(0)) begin
      errors++;
      $display("FAIL basic_read: got we=%0b addr=%0h, want 0 0", cap_we2, cap_addr2);
    end
    checks++;
    if (cap_valid3 !== 1'b0 || cap_valid4 !== 1'b1 || cap_busy4 !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: got v3=%0b v4=%0b busy4=%0b, want 0 1 0", cap_valid3, cap_valid4, cap_busy4);
    end
    checks++;
    if (cap_out4 !== 18'h00100 || cap_out4 !== eo) begin
      errors++;
      $display("FAIL basic_out: got %05h, want 00100", cap_out4);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0 || mem_we !== 1'b0 || mem_addr !== ADDR_W'(0)) begin
      errors++;
      $display("FAIL basic_after: got v=%0b ovr=%0b we=%0b addr=%0h, want 0 0 0 0", out_valid, overrun, mem_we, mem_addr);
    end
  endtask

  task automatic test_delay_fill();
    logic [17:0] eo, want; int wa, ra;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      model_step(18'h01000, 8'h01, eo, wa, ra);
      run_sample(18'h01000, 8'h01);
      want = (k < 16) ? 18'h00800 : 18'h01000;
      checks++;
      if (cap_out4 !== want || cap_out4 !== eo || cap_valid4 !== 1'b1) begin
        errors++;
        $display("FAIL delay_fill k=%0d: got %05h v=%0b, want %05h", k, cap_out4, cap_valid4, want);
      end
      if (k == 16) begin
        checks++;
        if (cap_addr2 !== ADDR_W'(0)) begin
          errors++;
          $display("FAIL delay_read_addr: got %0h, want 0", cap_addr2);
        end
      end
      repeat (4) @(posedge clock);
    end
  endtask

  task automatic test_negative_mix();
    logic [17:0] eo, s; int wa, ra;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      s = (k == 0) ? 18'h3FFFF : (k == 16) ? 18'h20000 : 18'h1FFFF;
      model_step(s, 8'h01, eo, wa, ra);
      run_sample(s, 8'h01);
      checks++;
      if (cap_out4 !== eo) begin
        errors++;
        $display("FAIL neg_model k=%0d: got %05h, want %05h", k, cap_out4, eo);
      end
    end
    checks++;
    if (cap_out4 !== 18'h1FFFF) begin
      errors++;
      $display("FAIL pos_max_mix: got %05h, want 1ffff", cap_out4);
    end
  endtask

  task automatic test_wrap();
    logic [17:0] eo; int wa, ra;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      model_step(18'(k), 8'h01, eo, wa, ra);
      run_sample(18'(k), 8'h01);
      checks++;
      if (cap_out4 !== eo || cap_addr1 !== ADDR_W'(wa) || cap_addr2 !== ADDR_W'(ra)) begin
        errors++;
        $display("FAIL wrap k=%0d: got out=%05h wa=%0d ra=%0d, want out=%05h wa=%0d ra=%0d",
                 k, cap_out4, cap_addr1, cap_addr2, eo, wa, ra);
      end
      if (k == 260) begin
        checks++;
        if (cap_addr1 !== ADDR_W'(4) || cap_addr2 !== ADDR_W'(244) || cap_out4 !== 18'd252) begin
          errors++;
          $display("FAIL wrap_260: got wa=%0d ra=%0d out=%0d, want 4 244 252", cap_addr1, cap_addr2, cap_out4);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] ea, ec, eo; int wa, ra;
    do_reset();
    model_step(18'h00AAA, 8'h00, ea, wa, ra);
    @(negedge clock); ready = 1'b1; audio_in = 18'h00AAA; controls = 8'h00;
    @(negedge clock); ready = 1'b0;
    @(negedge clock); ready = 1'b1; audio_in = 18'h00BBB;
    @(negedge clock); ready = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got ovr=%0b busy=%0b, want 1 1", overrun, busy);
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || audio_out !== ea || overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_first: got v=%0b out=%05h ovr=%0b busy=%0b, want 1 %05h 1 0",
               out_valid, audio_out, overrun, busy, ea);
    end
    model_step(18'h00CCC, 8'h00, ec, wa, ra);
    ready = 1'b1; audio_in = 18'h00CCC;
    @(negedge clock); ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || audio_out !== ec || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_next: got v=%0b out=%05h ovr=%0b, want 1 %05h 1", out_valid, audio_out, overrun, ec);
    end
    // Reset while the READ cycle is in progress.
    @(negedge clock); ready = 1'b1; audio_in = 18'h01234; controls = 8'h00;
    @(negedge clock); ready = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({mem_addr, mem_we, mem_din, audio_out, out_valid, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got addr=%0h we=%0b din=%0h out=%0h v=%0b busy=%0b ovr=%0b, want all 0",
               mem_addr, mem_we, mem_din, audio_out, out_valid, busy, overrun);
    end
    reset = 1'b0;
    hist.delete();
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: got v=%0b busy=%0b, want 0 0", out_valid, busy);
    end
    model_step(18'h00400, 8'h01, eo, wa, ra);
    run_sample(18'h00400, 8'h01);
    checks++;
    if (cap_out4 !== 18'h00200 || cap_out4 !== eo || cap_addr1 !== ADDR_W'(0)) begin
      errors++;
      $display("FAIL reset_fill_cleared: got out=%05h wa=%0d, want 00200 0", cap_out4, cap_addr1);
    end
  endtask

  task automatic test_bypass();
    logic [17:0] eo, s; int wa, ra;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      s = 18'(100 + k);
      model_step(s, 8'h81, eo, wa, ra);
      run_sample(s, 8'h81);
      checks++;
      if (cap_out4 !== s || cap_out4 !== eo || cap_valid4 !== 1'b1 || cap_we1 !== 1'b1) begin
        errors++;
        $display("FAIL bypass k=%0d: got out=%05h v=%0b we=%0b, want %05h 1 1", k, cap_out4, cap_valid4, cap_we1, s);
      end
    end
    model_step(18'd120, 8'h01, eo, wa, ra);
    run_sample(18'd120, 8'h01);
    checks++;
    if (cap_out4 !== 18'd112 || cap_out4 !== eo) begin
      errors++;
      $display("FAIL bypass_release: got %0d, want 112", cap_out4);
    end
  endtask

  task automatic test_random();
    logic [17:0] eo, s; logic [7:0] c; int wa, ra;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      s = 18'($urandom);
      c = {1'($urandom_range(0, 3) == 0), 3'd0, 4'($urandom)};
      model_step(s, c, eo, wa, ra);
      run_sample(s, c);
      checks++;
      if (cap_out4 !== eo || cap_valid4 !== 1'b1 || cap_valid3 !== 1'b0 || cap_din1 !== s ||
          cap_addr1 !== ADDR_W'(wa) || cap_addr2 !== ADDR_W'(ra) || cap_we2 !== 1'b0) begin
        errors++;
        $display("FAIL random k=%0d c=%02h: got out=%05h v=%0b wa=%0d ra=%0d din=%05h, want out=%05h wa=%0d ra=%0d din=%05h",
                 k, c, cap_out4, cap_valid4, cap_addr1, cap_addr2, cap_din1, eo, wa, ra, s);
      end
      repeat ($urandom_range(0, 3)) @(posedge clock);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL random_overrun: got %0b, want 0", overrun);
    end
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; audio_in = '0; controls = '0;
    repeat (2) @(posedge clock);
    test_reset();
    test_basic();
    test_delay_fill();
    test_negative_mix();
    test_wrap();
    test_back_to_back();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
